conv_operand_loader: RTL and testbench
======================================

CONV_OPERAND_LOADER -- requirements
Module: conv_operand_loader

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, element width in bits.
REQ-002 SHALL have parameter N_ELEM, default 25, elements per matrix (5x5).
REQ-003 SHALL have parameter TIMEOUT, default 63, maximum WAIT_DONE cycles before abandoning the operation.
REQ-004 clk  input  1  clock; reset is asynchronous, active-high, named reset.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 in_valid / in_ready  input / output  1 / 1  byte-stream handshake.
REQ-007 in_data  input  8  signed operand element.
REQ-008 abort  input  1  synchronous discard of the operation in progress.
REQ-009 A_flat / B_flat  output  200 / 200  flattened matrices; element k at bits [k*8 +: 8].
REQ-010 alu_start  output  1  one-cycle start pulse to the convolution ALU.
REQ-011 alu_result / alu_overflow / alu_done  input  8 / 1 / 1  ALU outputs.
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out_data / out_overflow / out_timeout  output  8 / 1 / 1  captured result and status.
REQ-014 busy  output  1  high in every state except LOAD_A with element index 0.

Function
REQ-015 SHALL implement states LOAD_A, LOAD_B, START, WAIT_DONE and RESULT, with a 5-bit element index and a 6-bit wait counter.
REQ-016 in_ready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-017 On each in_valid&&in_ready handshake, in_data SHALL be written to element [index] of A (in LOAD_A) or B (in LOAD_B), and index SHALL increment.
REQ-018 On a handshake at index 24, index SHALL wrap to 0 and the state SHALL advance (LOAD_A->LOAD_B, LOAD_B->START).
REQ-019 In START, alu_start SHALL be 1 for exactly one cycle, then the state SHALL move to WAIT_DONE with the wait counter cleared.
REQ-020 A_flat and B_flat SHALL remain unchanged from START through RESULT, because the ALU reads them across its accumulation cycles.
REQ-021 WAIT_DONE SHALL ignore alu_done in its first cycle, since that level is stale from the previous operation.
REQ-022 From the second cycle of WAIT_DONE, alu_done=1 SHALL register alu_result into out_data and alu_overflow into out_overflow, set out_timeout=0 and out_valid=1, and move to RESULT.
REQ-023 When the wait counter reaches TIMEOUT without alu_done, the block SHALL set out_data=0, out_overflow=0, out_timeout=1 and out_valid=1, and move to RESULT.
REQ-024 In RESULT, out_valid and out_data/out_overflow/out_timeout SHALL be held until out_ready=1; on that handshake out_valid SHALL drop and the state SHALL return to LOAD_A with index 0.
REQ-025 Operand buffers SHALL NOT be cleared between operations; each new operation overwrites all elements.
REQ-026 abort=1 SHALL force LOAD_A, index 0, out_valid=0 and alu_start=0 on the next edge, from any state; abort has priority over any simultaneous handshake.
REQ-027 An abort in WAIT_DONE SHALL leave the ALU running and discard its eventual done.
REQ-028 Latency: the ALU is started 1 cycle after the 50th input byte; out_valid follows the first accepted alu_done by 1 cycle.

Reset
REQ-029 reset SHALL force LOAD_A, index 0, wait counter 0, in_ready=1 (combinational from state), alu_start=0, out_valid=0, out_data=0, out_overflow=0, out_timeout=0, busy=0, and A_flat=B_flat=0.
REQ-030 Reset asserted mid-operation SHALL discard all partial operands and any pending result.

Structure
REQ-031 The shared package SHALL hold ELEM_W, N_ELEM, the flattened width (N_ELEM*ELEM_W), the TIMEOUT default and the state encoding.
REQ-032 The operand storage SHALL be one sub-module, conv_operand_buffer: 2xN_ELEM byte registers with an indexed write port and flat A/B outputs; control stays in the top level.

Verification
REQ-033 50 bytes of 0x01 followed by an ALU model -> alu_start pulses once, then out_data=25, out_overflow=0, out_timeout=0.
REQ-034 A all 0x10, B all 0x10 -> the ALU sum of 6400 yields out_data=255, out_overflow=1.
REQ-035 alu_done tied to 0 -> out_valid rises 64 cycles after alu_start, with out_timeout=1 and out_data=0.
REQ-036 out_ready held low for 10 cycles in RESULT -> out_valid and out_data stable, in_ready=0; the handshake on cycle 11 returns the block to LOAD_A.
REQ-037 abort after 30 bytes -> index 0, LOAD_A; the next 50 bytes form a correct operation, with A element 0 equal to the 31st byte sent overall.
REQ-038 reset asserted during WAIT_DONE -> all outputs return to reset values; a stale alu_done=1 at the first WAIT_DONE cycle of the next operation is ignored.

Source files
------------

// File: rtl/conv_operand_loader_pkg.sv
// Shared sizing constants and state encoding for the convolution operand loader.
package conv_operand_loader_pkg;

    localparam int ELEM_W_DEF  = 8;
    localparam int N_ELEM_DEF  = 25;
    localparam int FLAT_W_DEF  = N_ELEM_DEF * ELEM_W_DEF;
    localparam int TIMEOUT_DEF = 63;
    localparam int IDX_W       = 5;
    localparam int WCNT_W      = 6;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } state_t;

endpackage

// File: rtl/conv_operand_buffer.sv
// Two banks of N_ELEM element registers (A and B) with one indexed write port.
// Both banks are exposed flattened, element k at bits [k*ELEM_W +: ELEM_W].
module conv_operand_buffer
    import conv_operand_loader_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int N_ELEM = N_ELEM_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [ELEM_W-1:0]        wr_data,
    output logic [N_ELEM*ELEM_W-1:0] a_flat,
    output logic [N_ELEM*ELEM_W-1:0] b_flat
);

    // wr_sel picks the bank: 0 writes A, 1 writes B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_flat <= '0;
            b_flat <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < N_ELEM; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    if (wr_sel)
                        b_flat[k*ELEM_W +: ELEM_W] <= wr_data;
                    else
                        a_flat[k*ELEM_W +: ELEM_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/conv_operand_loader.sv
// Streams two N_ELEM-element operand matrices in, kicks the convolution ALU,
// and holds its result (or a timeout status) until the consumer takes it.
module conv_operand_loader
    import conv_operand_loader_pkg::*;
#(
    parameter int ELEM_W  = ELEM_W_DEF,
    parameter int N_ELEM  = N_ELEM_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ELEM_W-1:0] in_data,
    input  logic                     abort,
    output logic [N_ELEM*ELEM_W-1:0] A_flat,
    output logic [N_ELEM*ELEM_W-1:0] B_flat,
    output logic                     alu_start,
    input  logic [ELEM_W-1:0]        alu_result,
    input  logic                     alu_overflow,
    input  logic                     alu_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W-1:0]        out_data,
    output logic                     out_overflow,
    output logic                     out_timeout,
    output logic                     busy
);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
    logic                valid_nxt, ovf_nxt, tmo_nxt;
    logic [ELEM_W-1:0]   data_nxt;
    logic                take;

    // An aborted cycle must not write the buffer even if a byte is offered.
    assign take = in_valid && in_ready && !abort;

    conv_operand_buffer #(
        .ELEM_W (ELEM_W),
        .N_ELEM (N_ELEM)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (take),
        .wr_sel  (state == LOAD_B),
        .wr_idx  (idx),
        .wr_data (in_data),
        .a_flat  (A_flat),
        .b_flat  (B_flat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD_A;
            idx          <= '0;
            wcnt         <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            wcnt         <= wcnt_nxt;
            out_valid    <= valid_nxt;
            out_data     <= data_nxt;
            out_overflow <= ovf_nxt;
            out_timeout  <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wcnt_nxt  = wcnt;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        ovf_nxt   = out_overflow;
        tmo_nxt   = out_timeout;
        in_ready  = 1'b0;
        alu_start = 1'b0;
        busy      = !(state == LOAD_A && idx == '0);

        case (state)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx == IDX_W'(N_ELEM - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = (state == LOAD_A) ? LOAD_B : START;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            START: begin
                alu_start = 1'b1;
                wcnt_nxt  = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // alu_done on the first cycle is still the previous operation's level
                if (wcnt != '0 && alu_done) begin
                    data_nxt  = alu_result;
                    ovf_nxt   = alu_overflow;
                    tmo_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = RESULT;
                end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                    data_nxt  = '0;
                    ovf_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = RESULT;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = LOAD_A;
                end
            end
            default: state_nxt = LOAD_A;
        endcase

        if (abort) begin
            state_nxt = LOAD_A;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader with a behavioural convolution ALU
// and a result scoreboard filled when each operation's operands are sent.
module tb_conv_operand_loader;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [7:0]  in_data = '0;
    logic               abort = 1'b0;
    logic [199:0]       A_flat, B_flat;
    logic               alu_start;
    logic [7:0]         alu_result = '0;
    logic               alu_overflow = 1'b0;
    logic               alu_done = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         out_data;
    logic               out_overflow, out_timeout, busy;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic       tmo;
    } res_t;

    res_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] a_v[25];
    logic [7:0] b_v[25];

    always #5 clk = ~clk;

    conv_operand_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .abort        (abort),
        .A_flat       (A_flat),
        .B_flat       (B_flat),
        .alu_start    (alu_start),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_done     (alu_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_timeout  (out_timeout),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] pack(input bit sel);
        logic [199:0] f;
        f = '0;
        for (int k = 0; k < 25; k++)
            f[k*8 +: 8] = sel ? b_v[k] : a_v[k];
        return f;
    endfunction

    // Convolution ALU behaviour: signed dot product, clamped to 0..255 with overflow flag.
    function automatic res_t model(input logic [199:0] a, input logic [199:0] b);
        int   sum;
        res_t r;
        sum = 0;
        for (int k = 0; k < 25; k++)
            sum += int'($signed(a[k*8 +: 8])) * int'($signed(b[k*8 +: 8]));
        r.tmo = 1'b0;
        if (sum > 255) begin
            r.data = 8'hFF; r.ovf = 1'b1;
        end else if (sum < 0) begin
            r.data = 8'h00; r.ovf = 1'b1;
        end else begin
            r.data = sum[7:0]; r.ovf = 1'b0;
        end
        return r;
    endfunction

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_alu_start", alu_start, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_overflow", out_overflow, 1'b0);
        check("rst_out_timeout", out_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_A_flat", A_flat, 200'd0);
        check("rst_B_flat", B_flat, 200'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Sends A then B; returns one step after the 50th handshake (the START cycle).
    task automatic load_op(input bit expect_timeout);
        res_t e;
        for (int k = 0; k < 25; k++) send_byte(a_v[k]);
        for (int k = 0; k < 25; k++) send_byte(b_v[k]);
        check("alu_start_rise", alu_start, 1'b1);
        check("A_flat_loaded", A_flat, pack(1'b0));
        check("B_flat_loaded", B_flat, pack(1'b1));
        if (expect_timeout) begin
            e.data = 8'h00; e.ovf = 1'b0; e.tmo = 1'b1;
        end else begin
            e = model(pack(1'b0), pack(1'b1));
        end
        sb.push_back(e);
    endtask

    // Called in the START cycle; stale result A5 is visible until WAIT_DONE's second cycle.
    task automatic alu_run(input int lat, input bit never_done, input bit force_stale);
        res_t r;
        int   n;
        alu_result   = 8'hA5;
        alu_overflow = 1'b1;
        if (force_stale) alu_done = 1'b1;
        @(posedge clk); #1;
        check("alu_start_pulse", alu_start, 1'b0);
        @(posedge clk); #1;
        check("stale_done_ignored", out_valid, 1'b0);
        alu_done = 1'b0;
        if (never_done) begin
            n = 2;
            while (!out_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("timeout_latency", n, 64);
        end else begin
            repeat (lat) begin @(posedge clk); #1; end
            r            = model(A_flat, B_flat);
            alu_result   = r.data;
            alu_overflow = r.ovf;
            alu_done     = 1'b1;
            check("valid_before_done", out_valid, 1'b0);
            @(posedge clk); #1;
            check("done_to_valid", out_valid, 1'b1);
        end
    endtask

    task automatic collect(input int hold);
        res_t       e;
        logic [7:0] d;
        d = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, d);
            check("hold_in_ready", in_ready, 1'b0);
        end
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_overflow", out_overflow, e.ovf);
            check("out_timeout", out_timeout, e.tmo);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;

        // all ones -> 25
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'h01; b_v[k] = 8'h01; end
        load_op(1'b0);
        alu_run(3, 1'b0, 1'b0);
        collect(0);

        // 0x10 x 0x10 x 25 = 6400 -> saturated, consumer stalls 10 cycles
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'h10; b_v[k] = 8'h10; end
        load_op(1'b0);
        alu_run(5, 1'b0, 1'b0);
        collect(10);

        // ALU never answers
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'(k); b_v[k] = 8'(k + 1); end
        load_op(1'b1);
        alu_run(0, 1'b1, 1'b0);
        collect(2);

        // small random operands
        for (int k = 0; k < 25; k++) begin
            a_v[k] = 8'($urandom_range(0, 3));
            b_v[k] = 8'($urandom_range(0, 3));
        end
        load_op(1'b0);
        alu_run(1, 1'b0, 1'b0);
        collect(1);

        // abort after 30 bytes; the byte offered alongside abort is dropped
        for (int k = 0; k < 30; k++) send_byte(8'(100 + k));
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'(k + 3); b_v[k] = 8'(k % 2); end
        load_op(1'b0);
        check("A0_is_31st_byte", A_flat[7:0], 8'h03);
        alu_run(2, 1'b0, 1'b0);
        collect(0);

        // abort while waiting; the late done must be discarded
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'h02; b_v[k] = 8'h03; end
        load_op(1'b0);
        alu_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sb.delete();
        check("wabort_busy", busy, 1'b0);
        check("wabort_out_valid", out_valid, 1'b0);
        check("wabort_alu_start", alu_start, 1'b0);
        alu_result   = 8'h5A;
        alu_overflow = 1'b0;
        alu_done     = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("late_done_discarded", out_valid, 1'b0);
        end

        // negative sum -> clamped to 0 with overflow; done still high from above
        for (int k = 0; k < 25; k++) begin
            a_v[k] = 8'(k - 12);
            b_v[k] = (k < 12) ? 8'h02 : 8'h01;
        end
        load_op(1'b0);
        alu_run(4, 1'b0, 1'b0);
        collect(0);

        // asynchronous reset during WAIT_DONE
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'h02; b_v[k] = 8'h02; end
        load_op(1'b0);
        alu_done = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        @(negedge clk);
        reset = 1'b0;

        // first op after reset sees a stale done at the start of WAIT_DONE
        for (int k = 0; k < 25; k++) begin a_v[k] = 8'h01; b_v[k] = 8'h01; end
        load_op(1'b0);
        alu_run(2, 1'b0, 1'b1);
        collect(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
